// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_pkg
// Description : Shared types, geometry constants and address-field helpers
//               for the direct-mapped write-through data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

    localparam int LINE_BITS     = 512;
    localparam int WORD_BITS     = 32;
    localparam int OFFSET_BITS   = 6;
    localparam int WORD_SEL_BITS = OFFSET_BITS - 2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_WAIT_LO = 3'd1,
        RD_WAIT_HI = 3'd2,
        WR_WAIT_LO = 3'd3,
        WR_WAIT_HI = 3'd4
    } state_t;

    // Word-within-line selector of a byte address.
    function automatic logic [WORD_SEL_BITS-1:0] addr_word(input logic [31:0] addr);
        return addr[OFFSET_BITS-1:2];
    endfunction

    // Line index of a byte address; caller truncates to its index width.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_bits);
        return (addr >> OFFSET_BITS) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    // Tag of a byte address; caller truncates to its tag width.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_bits);
        return addr >> (OFFSET_BITS + idx_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_array
// Description : Valid/tag/data storage for the data cache. Valid bits are
//               asynchronously cleared; tags and data are not reset.
//               Combinational read port, whole-line fill port, word-write port.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
    import data_cache_pkg::*;
#(
    parameter  int LINES    = 16,
    localparam int IDX_BITS = $clog2(LINES),
    localparam int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [IDX_BITS-1:0]      rd_index,
    output logic                     rd_valid,
    output logic [TAG_BITS-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]     rd_line,
    input  logic                     fill_en,
    input  logic [IDX_BITS-1:0]      fill_index,
    input  logic [TAG_BITS-1:0]      fill_tag,
    input  logic [LINE_BITS-1:0]     fill_line,
    input  logic                     word_we,
    input  logic [IDX_BITS-1:0]      word_index,
    input  logic [WORD_SEL_BITS-1:0] word_sel,
    input  logic [WORD_BITS-1:0]     word_data
);

    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tags [LINES];
    logic [LINE_BITS-1:0] data [LINES];

    // Valid bits: cleared by reset, set when a line is installed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_index] <= 1'b1;
        end
    end

    // Tag/data storage: line fill has priority; the FSM never issues both at once.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tags[fill_index] <= fill_tag;
            data[fill_index] <= fill_line;
        end else if (word_we) begin
            data[word_index][32'(word_sel) * WORD_BITS +: WORD_BITS] <= word_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = data[rd_index];

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-through, no-write-allocate data cache.
//               Word reads/writes from the CPU, 512-bit line fills from memory
//               on read misses, every write forwarded to memory as one word.
//               Optional macro DCACHE_STATS_EN adds read hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    output logic                 mem_read_req,
    output logic [31:0]          mem_read_addr,
    input  logic                 mem_read_done,
    input  logic [LINE_BITS-1:0] mem_line_in,
    output logic                 mem_write_req,
    output logic [31:0]          mem_write_addr,
    output logic [31:0]          mem_write_data,
    input  logic                 mem_write_done
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses
`endif
);

    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS;

    state_t state;
    state_t state_next;

    logic [31:0]          req_addr;
    logic                 lookup_valid;
    logic [TAG_BITS-1:0]  lookup_tag;
    logic [LINE_BITS-1:0] lookup_line;
    logic                 lookup_hit;
    logic [IDX_BITS-1:0]  cpu_index;
    logic [TAG_BITS-1:0]  cpu_tag;
    logic                 rd_hit_acc;
    logic                 rd_miss_acc;
    logic                 wr_acc;
    logic                 rd_fill;
    logic                 wr_finish;

    assign cpu_index  = IDX_BITS'(addr_index(cpu_addr, IDX_BITS));
    assign cpu_tag    = TAG_BITS'(addr_tag(cpu_addr, IDX_BITS));
    assign lookup_hit = lookup_valid && (lookup_tag == cpu_tag);

    dcache_array #(
        .LINES (LINES)
    ) u_array (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_index   (cpu_index),
        .rd_valid   (lookup_valid),
        .rd_tag     (lookup_tag),
        .rd_line    (lookup_line),
        .fill_en    (rd_fill),
        .fill_index (IDX_BITS'(addr_index(req_addr, IDX_BITS))),
        .fill_tag   (TAG_BITS'(addr_tag(req_addr, IDX_BITS))),
        .fill_line  (mem_line_in),
        .word_we    (wr_acc && lookup_hit),
        .word_index (cpu_index),
        .word_sel   (addr_word(cpu_addr)),
        .word_data  (cpu_wdata)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and one-cycle event strobes for the output registers.
    always_comb begin
        state_next  = state;
        rd_hit_acc  = 1'b0;
        rd_miss_acc = 1'b0;
        wr_acc      = 1'b0;
        rd_fill     = 1'b0;
        wr_finish   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        wr_acc     = 1'b1;
                        state_next = WR_WAIT_LO;
                    end else if (lookup_hit) begin
                        rd_hit_acc = 1'b1;
                    end else begin
                        rd_miss_acc = 1'b1;
                        state_next  = RD_WAIT_LO;
                    end
                end
            end
            RD_WAIT_LO: if (!mem_read_done) state_next = RD_WAIT_HI;
            RD_WAIT_HI: begin
                if (mem_read_done) begin
                    rd_fill    = 1'b1;
                    state_next = IDLE;
                end
            end
            WR_WAIT_LO: if (!mem_write_done) state_next = WR_WAIT_HI;
            WR_WAIT_HI: begin
                if (mem_write_done) begin
                    wr_finish  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered CPU/memory outputs and the latched miss address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ready      <= 1'b0;
            cpu_rdata      <= '0;
            mem_read_req   <= 1'b0;
            mem_read_addr  <= '0;
            mem_write_req  <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            req_addr       <= '0;
        end else begin
            cpu_ready     <= rd_hit_acc | rd_fill | wr_finish;
            mem_read_req  <= rd_miss_acc;
            mem_write_req <= wr_acc;
            if (rd_hit_acc) begin
                cpu_rdata <= lookup_line[32'(addr_word(cpu_addr)) * WORD_BITS +: WORD_BITS];
            end else if (rd_fill) begin
                cpu_rdata <= mem_line_in[32'(addr_word(req_addr)) * WORD_BITS +: WORD_BITS];
            end
            if (rd_miss_acc) begin
                req_addr      <= cpu_addr;
                mem_read_addr <= {cpu_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
            if (wr_acc) begin
                mem_write_addr <= {cpu_addr[31:2], 2'b00};
                mem_write_data <= cpu_wdata;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // Read hit/miss counters; writes are not counted, wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (rd_hit_acc)  stat_hits   <= stat_hits + 32'd1;
            if (rd_miss_acc) stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Self-checking bench for data_cache: directed scenarios plus a
//               random read/write mix against a memory/tag reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         mem_read_req;
    logic [31:0]  mem_read_addr;
    logic         mem_read_done;
    logic [511:0] mem_line_in;
    logic         mem_write_req;
    logic [31:0]  mem_write_addr;
    logic [31:0]  mem_write_data;
    logic         mem_write_done;

    int checks = 0;
    int errors = 0;

    // Reference: backing memory (sparse, word-addressed) and resident tags.
    logic [31:0] mem [logic [31:0]];
    bit          ref_valid [16];
    logic [21:0] ref_tag   [16];
    int          rd_hold = 0;
    logic [31:0] rd_base;
    int          rd_lat;
    int          wr_lat;

    always #5 clock = ~clock;

    data_cache #(.LINES(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .mem_read_req   (mem_read_req),
        .mem_read_addr  (mem_read_addr),
        .mem_read_done  (mem_read_done),
        .mem_line_in    (mem_line_in),
        .mem_write_req  (mem_write_req),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_done (mem_write_done)
    );

    function automatic logic [31:0] memrd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem.exists(w)) return mem[w];
        return w * 32'h9E37_79B9 + 32'h1357_2468;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory read side: drop done on request, raise it with the line later.
    initial begin
        mem_read_done = 1'b1;
        mem_line_in   = '0;
        forever begin
            @(negedge clock);
            if (mem_read_req === 1'b1) begin
                rd_base       = mem_read_addr;
                rd_lat        = (rd_hold > 0) ? rd_hold : int'($urandom_range(1, 4));
                mem_read_done = 1'b0;
                repeat (rd_lat) @(negedge clock);
                for (int k = 0; k < 16; k++) mem_line_in[32*k +: 32] = memrd(rd_base + 32'(4*k));
                mem_read_done = 1'b1;
            end
        end
    end

    // Memory write side: commit the word, then low-then-high done handshake.
    initial begin
        mem_write_done = 1'b1;
        forever begin
            @(negedge clock);
            if (mem_write_req === 1'b1) begin
                mem[{mem_write_addr[31:2], 2'b00}] = mem_write_data;
                wr_lat         = int'($urandom_range(1, 4));
                mem_write_done = 1'b0;
                repeat (wr_lat) @(negedge clock);
                mem_write_done = 1'b1;
            end
        end
    end

    // One CPU transaction, entered just after a negedge; checks against the model.
    task automatic do_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int          cyc;
        bit          saw_rd;
        bit          saw_wr;
        bit          hit;
        int          idx;
        logic [31:0] rd_a;
        logic [31:0] wr_a;
        logic [31:0] wr_d;
        idx    = int'(addr[9:6]);
        hit    = ref_valid[idx] && (ref_tag[idx] == addr[31:10]);
        cyc    = 0;
        saw_rd = 1'b0;
        saw_wr = 1'b0;
        rd_a   = '0;
        wr_a   = '0;
        wr_d   = '0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        while (1) begin
            @(negedge clock);
            cyc++;
            cpu_req   = 1'b0;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom();
            cpu_wdata = $urandom();
            if (mem_read_req === 1'b1) begin saw_rd = 1'b1; rd_a = mem_read_addr; end
            if (mem_write_req === 1'b1) begin saw_wr = 1'b1; wr_a = mem_write_addr; wr_d = mem_write_data; end
            if (cpu_ready === 1'b1 || cyc > 100) break;
        end
        check({tag, " ready_timeout"}, 32'(cyc > 100), 32'd0);
        if (we) begin
            check({tag, " wr_req"}, 32'(saw_wr), 32'd1);
            check({tag, " wr_addr"}, wr_a, addr);
            check({tag, " wr_data"}, wr_d, wdata);
            check({tag, " wr_no_rd"}, 32'(saw_rd), 32'd0);
        end else begin
            check({tag, " rd_req_on_miss"}, 32'(saw_rd), 32'(!hit));
            if (hit) check({tag, " hit_latency"}, 32'(cyc), 32'd1);
            else     check({tag, " rd_addr"}, rd_a, {addr[31:6], 6'b0});
            check({tag, " rdata"}, cpu_rdata, memrd(addr));
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = addr[31:10];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 16; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = '0; end
        mem[32'h40] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clock);
        check("reset cpu_ready", 32'(cpu_ready), 32'd0);
        check("reset mem_read_req", 32'(mem_read_req), 32'd0);
        check("reset mem_write_req", 32'(mem_write_req), 32'd0);
        check("reset cpu_rdata", cpu_rdata, 32'd0);
        check("reset mem_read_addr", mem_read_addr, 32'd0);
        check("reset mem_write_addr", mem_write_addr, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed scenarios.
        do_op(1'b0, 32'h40, 32'h0, "miss_0x40");
        check("word0 deadbeef", cpu_rdata, 32'hDEAD_BEEF);
        do_op(1'b0, 32'h40, 32'h0, "hit_0x40");
        do_op(1'b0, 32'h44, 32'h0, "hit_0x44");
        do_op(1'b1, 32'h48, 32'h1234_5678, "wr_hit_0x48");
        do_op(1'b0, 32'h48, 32'h0, "rd_0x48");
        check("0x48 new data", cpu_rdata, 32'h1234_5678);
        do_op(1'b1, 32'h2000, 32'hCAFE_F00D, "wr_miss_0x2000");
        do_op(1'b0, 32'h2000, 32'h0, "rd_0x2000");
        do_op(1'b0, 32'h40, 32'h0, "rd_0x40_again");
        do_op(1'b0, 32'h440, 32'h0, "evict_0x440");
        do_op(1'b0, 32'h40, 32'h0, "reread_0x40");

        // Reset while the fill is pending; the line must not appear.
        rd_hold   = 6;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h3000;
        @(negedge clock);
        cpu_req = 1'b0;
        check("rst mem_read_req", 32'(mem_read_req), 32'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst mem_read_req low", 32'(mem_read_req), 32'd0);
        check("rst mem_read_addr", mem_read_addr, 32'd0);
        check("rst cpu_rdata", cpu_rdata, 32'd0);
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        for (int i = 0; i < 40 && mem_read_done !== 1'b1; i++) @(negedge clock);
        check("rst mem done", 32'(mem_read_done), 32'd1);
        rd_hold = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_op(1'b0, 32'h3000, 32'h0, "after_rst_0x3000");

        // Random mix over a small address space for frequent hits and conflicts.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 6)
              | (32'($urandom_range(0, 15)) << 2);
            do_op(($urandom_range(0, 2) == 0), a, $urandom(), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
